// File: rtl/cordic_iter_core.sv
// cordic_iter_core: iterative CORDIC engine (rotation / vectoring) with
// quadrant pre-rotation, arctan ROM and valid/ready handshakes on both sides.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a COMP state that scales
// x/y by 1/K so the results come out unity-gain (one extra cycle of latency).
module cordic_iter_core #(
    parameter int WIDTH = 16,
    parameter int ITER  = 12,
    localparam int CW   = $clog2(ITER + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [WIDTH-1:0]        x_in,
    input  logic [WIDTH-1:0]        y_in,
    input  logic [WIDTH-1:0]        z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH+1:0]        x_out,
    output logic [WIDTH+1:0]        y_out,
    output logic [WIDTH-1:0]        z_out,
    output logic                    busy
);

    localparam int XW = WIDTH + 2;
    localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};

    // atan(2^-i) in 16-bit binary angle units, rescaled to WIDTH on lookup
    localparam logic [15:0] ATAN_ROM [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 stateQ, stateD;
    logic signed [XW-1:0]   xQ, xD, yQ, yD;
    logic [WIDTH-1:0]       zQ, zD;
    logic [CW-1:0]          cntQ, cntD;
    logic                   modeQ, modeD;

    logic                   accept;
    logic                   lastIter;
    logic                   dirPos;
    logic signed [XW-1:0]   xExt, yExt;
    logic signed [XW-1:0]   xShift, yShift;
    logic [WIDTH-1:0]       atanI;

    function automatic logic [WIDTH-1:0] atanLookup(input logic [CW-1:0] idx);
        logic [15:0] entry;
        entry = ATAN_ROM[4'(idx)];
        return WIDTH'(entry >> (16 - WIDTH));
    endfunction

    assign accept   = in_valid & in_ready;
    assign lastIter = (cntQ == CW'(ITER - 1));
    assign xExt     = {{2{x_in[WIDTH-1]}}, x_in};
    assign yExt     = {{2{y_in[WIDTH-1]}}, y_in};
    assign xShift   = xQ >>> cntQ;
    assign yShift   = yQ >>> cntQ;
    assign atanI    = atanLookup(cntQ);
    // rotation steers z toward 0, vectoring steers y toward 0
    assign dirPos   = modeQ ? yQ[XW-1] : ~zQ[WIDTH-1];

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [WIDTH:0] GAIN_K =
        (WIDTH+1)'(int'(0.6072529 * real'(64'd1 << WIDTH)));
    logic signed [XW+WIDTH:0] xProd, yProd;
    assign xProd = xQ * GAIN_K;
    assign yProd = yQ * GAIN_K;
`endif

    // State register with immediate asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state decode: accept, count micro-rotations, optionally compensate, hand off
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: if (accept) stateD = RUN;
            RUN: begin
                if (lastIter) begin
`ifdef CORDIC_GAIN_COMP_EN
                    stateD = COMP;
`else
                    stateD = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: stateD = DONE;
`endif
            DONE: if (out_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Handshake and status outputs are pure decodes of the state register
    always_comb begin
        in_ready  = (stateQ == IDLE);
        busy      = (stateQ != IDLE);
        out_valid = (stateQ == DONE);
    end

    // Datapath next values: pre-rotation on accept, one micro-rotation per RUN cycle
    always_comb begin
        xD    = xQ;
        yD    = yQ;
        zD    = zQ;
        cntD  = cntQ;
        modeD = modeQ;
        case (stateQ)
            IDLE: begin
                if (accept) begin
                    modeD = mode;
                    cntD  = '0;
                    xD    = xExt;
                    yD    = yExt;
                    zD    = z_in;
                    if (!mode) begin
                        if (z_in[WIDTH-1 -: 2] == 2'b01) begin
                            xD = -yExt;
                            yD = xExt;
                            zD = z_in - QUARTER;
                        end else if (z_in[WIDTH-1 -: 2] == 2'b10) begin
                            xD = yExt;
                            yD = -xExt;
                            zD = z_in + QUARTER;
                        end
                    end else if (xExt[XW-1]) begin
                        if (!yExt[XW-1]) begin
                            xD = yExt;
                            yD = -xExt;
                            zD = z_in + QUARTER;
                        end else begin
                            xD = -yExt;
                            yD = xExt;
                            zD = z_in - QUARTER;
                        end
                    end
                end
            end
            RUN: begin
                cntD = cntQ + CW'(1);
                if (dirPos) begin
                    xD = xQ - yShift;
                    yD = yQ + xShift;
                    zD = zQ - atanI;
                end else begin
                    xD = xQ + yShift;
                    yD = yQ - xShift;
                    zD = zQ + atanI;
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                xD = XW'(xProd >>> WIDTH);
                yD = XW'(yProd >>> WIDTH);
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xQ    <= '0;
            yQ    <= '0;
            zQ    <= '0;
            cntQ  <= '0;
            modeQ <= 1'b0;
        end else begin
            xQ    <= xD;
            yQ    <= yD;
            zQ    <= zD;
            cntQ  <= cntD;
            modeQ <= modeD;
        end
    end

    assign x_out = xQ;
    assign y_out = yQ;
    assign z_out = zQ;

endmodule
